axi_lite_regfile: RTL and testbench

AXI_LITE_REGFILE -- requirements
Module: axi_lite_regfile

---
 rtl/axi_lite_regfile_if.sv | 43 ++++
 rtl/axi_lite_regfile.sv | 128 ++++++++++++
 tb/tb_axi_lite_regfile.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_regfile_if.sv
// AXI-Lite channel bundle shared by the register file and whatever drives it.
// clk/rstn ride along for agents that want them; the register file does not use them.
interface axi_lite_channel #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input logic clk,
  input logic rstn
);
  logic                    aw_valid;
  logic                    aw_ready;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [2:0]              aw_prot;
  logic                    w_valid;
  logic                    w_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    b_valid;
  logic                    b_ready;
  logic [1:0]              b_resp;
  logic                    ar_valid;
  logic                    ar_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [2:0]              ar_prot;
  logic                    r_valid;
  logic                    r_ready;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;

  modport slave (
    input  clk, rstn,
    input  aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
    input  ar_valid, ar_addr, ar_prot, r_ready,
    output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );

  modport master (
    input  clk, rstn,
    output aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
    output ar_valid, ar_addr, ar_prot, r_ready,
    input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );
endinterface

// File: rtl/axi_lite_regfile.sv
// AXI-Lite register file: NUM_REGS words with byte strobes, one write outstanding.
// Define AXI_LITE_REGFILE_ERR_EN to answer out-of-range accesses with DECERR.
module axi_lite_regfile #(
  parameter int          NUM_REGS    = 16,
  parameter logic [63:0] RESET_VALUE = '0,
  parameter int          DATA_WIDTH  = 32,
  parameter int          ADDR_WIDTH  = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  axi_lite_channel.slave                 master,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs
);
  localparam int NB  = DATA_WIDTH / 8;
  localparam int OFF = $clog2(NB);
  localparam int IW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [DATA_WIDTH-1:0] RST_WORD = RESET_VALUE[DATA_WIDTH-1:0];
  localparam logic [1:0] OKAY = 2'b00;
`ifdef AXI_LITE_REGFILE_ERR_EN
  localparam logic [1:0] OOR_RESP = 2'b11;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64) || NUM_REGS < 1 || NUM_REGS > 256) begin : g_bad_cfg
    $fatal(1, "axi_lite_regfile: unsupported DATA_WIDTH or NUM_REGS");
  end

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];
  logic                  aw_full_reg, w_full_reg, aw_ready_reg, w_ready_reg, live_reg;
  logic                  b_valid_reg, r_valid_reg;
  logic [ADDR_WIDTH-1:0] aw_addr_reg;
  logic [DATA_WIDTH-1:0] w_data_reg, r_data_reg;
  logic [NB-1:0]         w_strb_reg;
  logic [1:0]            b_resp_reg, r_resp_reg;

  logic                  aw_hs, w_hs, ar_hs, ar_ready, commit;
  logic                  wr_in_range, rd_in_range;
  logic [ADDR_WIDTH-1:0] wr_addr, wr_word, rd_word;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NB-1:0]         wr_strb;
  logic [IW-1:0]         wr_idx, rd_idx;

  assign aw_hs    = master.aw_valid && aw_ready_reg;
  assign w_hs     = master.w_valid && w_ready_reg;
  assign ar_ready = live_reg && (!r_valid_reg || master.r_ready);
  assign ar_hs    = master.ar_valid && ar_ready;

  // A slot that is filling this cycle counts as full, so AW and W may arrive together.
  assign wr_addr = aw_full_reg ? aw_addr_reg : master.aw_addr;
  assign wr_data = w_full_reg ? w_data_reg : master.w_data;
  assign wr_strb = w_full_reg ? w_strb_reg : master.w_strb;
  assign commit  = (aw_full_reg || aw_hs) && (w_full_reg || w_hs) &&
                   (!b_valid_reg || master.b_ready);

  assign wr_word     = wr_addr >> OFF;
  assign rd_word     = master.ar_addr >> OFF;
  assign wr_in_range = wr_word < ADDR_WIDTH'(NUM_REGS);
  assign rd_in_range = rd_word < ADDR_WIDTH'(NUM_REGS);
  assign wr_idx      = wr_word[IW-1:0];
  assign rd_idx      = rd_word[IW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_reg     <= 1'b0;
      aw_full_reg  <= 1'b0;
      w_full_reg   <= 1'b0;
      aw_ready_reg <= 1'b0;
      w_ready_reg  <= 1'b0;
      aw_addr_reg  <= '0;
      w_data_reg   <= '0;
      w_strb_reg   <= '0;
      b_valid_reg  <= 1'b0;
      b_resp_reg   <= 2'b00;
      r_valid_reg  <= 1'b0;
      r_data_reg   <= '0;
      r_resp_reg   <= 2'b00;
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= RST_WORD;
    end else begin
      live_reg     <= 1'b1;
      aw_full_reg  <= !commit && (aw_full_reg || aw_hs);
      w_full_reg   <= !commit && (w_full_reg || w_hs);
      aw_ready_reg <= commit || !(aw_full_reg || aw_hs);
      w_ready_reg  <= commit || !(w_full_reg || w_hs);
      if (aw_hs) aw_addr_reg <= master.aw_addr;
      if (w_hs) begin
        w_data_reg <= master.w_data;
        w_strb_reg <= master.w_strb;
      end

      if (commit) begin
        b_valid_reg <= 1'b1;
        b_resp_reg  <= wr_in_range ? OKAY : OOR_RESP;
        if (wr_in_range) begin
          for (int k = 0; k < NB; k++)
            if (wr_strb[k]) mem[wr_idx][k*8 +: 8] <= wr_data[k*8 +: 8];
        end
      end else if (master.b_ready) begin
        b_valid_reg <= 1'b0;
      end

      // Nonblocking update of mem means a colliding read sees the pre-write word.
      if (ar_hs) begin
        r_valid_reg <= 1'b1;
        r_data_reg  <= rd_in_range ? mem[rd_idx] : '0;
        r_resp_reg  <= rd_in_range ? OKAY : OOR_RESP;
      end else if (master.r_ready) begin
        r_valid_reg <= 1'b0;
      end
    end
  end

  assign master.aw_ready = aw_ready_reg;
  assign master.w_ready  = w_ready_reg;
  assign master.b_valid  = b_valid_reg;
  assign master.b_resp   = b_resp_reg;
  assign master.ar_ready = ar_ready;
  assign master.r_valid  = r_valid_reg;
  assign master.r_data   = r_data_reg;
  assign master.r_resp   = r_resp_reg;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
    assign regs[gi*DATA_WIDTH +: DATA_WIDTH] = mem[gi];
  end

  logic unused_ok;
  assign unused_ok = ^{master.clk, master.rstn, master.aw_prot, master.ar_prot};
endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed bench for axi_lite_regfile (16 x 32-bit, RESET_VALUE 0).
// Out-of-range expectations follow AXI_LITE_REGFILE_ERR_EN.
module tb_axi_lite_regfile;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [16*32-1:0] regs;
  int checks = 0;
  int failures = 0;

`ifdef AXI_LITE_REGFILE_ERR_EN
  localparam logic [1:0] OOR_RESP = 2'b11;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  always #5 clk = ~clk;

  axi_lite_channel #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus (.clk(clk), .rstn(!rst));

  axi_lite_regfile #(.NUM_REGS(16), .RESET_VALUE(64'h0)) dut (
    .clk(clk), .rst(rst), .master(bus), .regs(regs)
  );

  function automatic logic [31:0] word(input int i);
    return regs[i*32 +: 32];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_full(input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic [1:0] exp_resp, input string name);
    logic got, aw_go, w_go;
    logic [1:0] resp;
    int n;
    got = 0; resp = 2'bxx; n = 0;
    bus.aw_addr = addr; bus.w_data = data; bus.w_strb = strb;
    bus.aw_valid = 1; bus.w_valid = 1; bus.b_ready = 1;
    while (!got && n < 20) begin
      aw_go = bus.aw_valid && bus.aw_ready;
      w_go  = bus.w_valid && bus.w_ready;
      if (bus.b_valid) begin got = 1; resp = bus.b_resp; end
      cyc();
      n++;
      if (aw_go) bus.aw_valid = 0;
      if (w_go) bus.w_valid = 0;
    end
    bus.aw_valid = 0; bus.w_valid = 0; bus.b_ready = 0;
    $display("txn write %s addr=%h data=%h strb=%h resp=%0d", name, addr, data, strb, resp);
    checks++;
    if (!got || resp !== exp_resp) begin
      failures++;
      $display("FAIL %s_bresp: got=%0b resp=%b required resp=%b", name, got, resp, exp_resp);
    end
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data,
                    output logic [1:0] resp, output logic got);
    logic ar_go;
    int n;
    got = 0; data = 'x; resp = 'x; n = 0;
    bus.ar_addr = addr; bus.ar_valid = 1; bus.r_ready = 1;
    while (!got && n < 20) begin
      ar_go = bus.ar_valid && bus.ar_ready;
      if (bus.r_valid) begin got = 1; data = bus.r_data; resp = bus.r_resp; end
      cyc();
      n++;
      if (ar_go) bus.ar_valid = 0;
    end
    bus.ar_valid = 0; bus.r_ready = 0;
    $display("txn read addr=%h data=%h resp=%0d", addr, data, resp);
  endtask

  task automatic test_reset();
    #12;
    checks++; if (bus.aw_ready !== 1'b0) begin failures++; $display("FAIL rst_aw_ready: got %b required 0", bus.aw_ready); end
    checks++; if (bus.w_ready !== 1'b0) begin failures++; $display("FAIL rst_w_ready: got %b required 0", bus.w_ready); end
    checks++; if (bus.ar_ready !== 1'b0) begin failures++; $display("FAIL rst_ar_ready: got %b required 0", bus.ar_ready); end
    checks++; if (bus.b_valid !== 1'b0 || bus.r_valid !== 1'b0) begin failures++; $display("FAIL rst_valids: got b=%b r=%b required 0 0", bus.b_valid, bus.r_valid); end
    checks++; if (regs !== '0) begin failures++; $display("FAIL rst_regs: got %h required 0", regs); end
    @(posedge clk); #1;
    rst = 0;
    cyc();
    checks++;
    if ({bus.aw_ready, bus.w_ready, bus.ar_ready} !== 3'b111) begin
      failures++; $display("FAIL post_rst_ready: got %b required 111", {bus.aw_ready, bus.w_ready, bus.ar_ready});
    end
    $display("txn reset released");
  endtask

  task automatic test_same_cycle();
    bus.aw_addr = 32'h8; bus.w_data = 32'hDEADBEEF; bus.w_strb = 4'hF;
    bus.aw_valid = 1; bus.w_valid = 1; bus.b_ready = 0;
    cyc();
    bus.aw_valid = 0; bus.w_valid = 0;
    checks++; if (bus.b_valid !== 1'b1) begin failures++; $display("FAIL same_b_valid: got %b required 1", bus.b_valid); end
    checks++; if (bus.b_resp !== 2'b00) begin failures++; $display("FAIL same_b_resp: got %b required 00", bus.b_resp); end
    checks++; if (word(2) !== 32'hDEADBEEF) begin failures++; $display("FAIL same_word2: got %h required deadbeef", word(2)); end
    bus.b_ready = 1;
    cyc();
    bus.b_ready = 0;
    checks++; if (bus.b_valid !== 1'b0) begin failures++; $display("FAIL same_b_drop: got %b required 0", bus.b_valid); end
    $display("txn write same-cycle addr=8 data=deadbeef");
  endtask

  task automatic test_split();
    wr_full(32'h4, 32'hAABBCCDD, 4'hF, 2'b00, "split_init");
    checks++; if (word(1) !== 32'hAABBCCDD) begin failures++; $display("FAIL split_init_word1: got %h required aabbccdd", word(1)); end
    bus.w_data = 32'h11223344; bus.w_strb = 4'h5; bus.w_valid = 1;
    cyc();
    bus.w_valid = 0;
    checks++; if (bus.w_ready !== 1'b0 || bus.aw_ready !== 1'b1) begin failures++; $display("FAIL split_w_slot: got w_ready=%b aw_ready=%b required 0 1", bus.w_ready, bus.aw_ready); end
    cyc(); cyc();
    checks++; if (bus.b_valid !== 1'b0) begin failures++; $display("FAIL split_early_b: got %b required 0", bus.b_valid); end
    bus.aw_addr = 32'h4; bus.aw_valid = 1;
    cyc();
    bus.aw_valid = 0;
    checks++; if (bus.b_valid !== 1'b1 || bus.b_resp !== 2'b00) begin failures++; $display("FAIL split_b: got valid=%b resp=%b required 1 00", bus.b_valid, bus.b_resp); end
    checks++; if (word(1) !== 32'hAA22CC44) begin failures++; $display("FAIL split_word1: got %h required aa22cc44", word(1)); end
    checks++; if (bus.w_ready !== 1'b1) begin failures++; $display("FAIL split_w_free: got %b required 1", bus.w_ready); end
    bus.b_ready = 1;
    cyc();
    bus.b_ready = 0;
    $display("txn write split addr=4 data=11223344 strb=5");
  endtask

  task automatic test_backpressure();
    bus.b_ready = 0;
    bus.aw_addr = 32'hC; bus.w_data = 32'h1; bus.w_strb = 4'hF;
    bus.aw_valid = 1; bus.w_valid = 1;
    cyc();
    bus.aw_valid = 0; bus.w_valid = 0;
    checks++; if (bus.b_valid !== 1'b1 || word(3) !== 32'h1) begin failures++; $display("FAIL bp_first: got b=%b word3=%h required 1 00000001", bus.b_valid, word(3)); end
    bus.aw_addr = 32'h10; bus.w_data = 32'h2;
    bus.aw_valid = 1; bus.w_valid = 1;
    cyc();
    bus.aw_valid = 0; bus.w_valid = 0;
    checks++; if (bus.aw_ready !== 1'b0 || bus.w_ready !== 1'b0) begin failures++; $display("FAIL bp_slots_full: got aw=%b w=%b required 0 0", bus.aw_ready, bus.w_ready); end
    repeat (4) cyc();
    checks++; if (word(4) !== 32'h0 || bus.b_valid !== 1'b1) begin failures++; $display("FAIL bp_held: got word4=%h b=%b required 0 1", word(4), bus.b_valid); end
    bus.b_ready = 1;
    cyc();
    checks++; if (word(4) !== 32'h2 || bus.b_valid !== 1'b1) begin failures++; $display("FAIL bp_second_commit: got word4=%h b=%b required 2 1", word(4), bus.b_valid); end
    checks++; if (bus.aw_ready !== 1'b1 || bus.w_ready !== 1'b1) begin failures++; $display("FAIL bp_slots_free: got aw=%b w=%b required 1 1", bus.aw_ready, bus.w_ready); end
    cyc();
    bus.b_ready = 0;
    checks++; if (bus.b_valid !== 1'b0) begin failures++; $display("FAIL bp_b_drop: got %b required 0", bus.b_valid); end
    $display("txn write backpressure addr=c,10");
  endtask

  task automatic test_read_collide();
    wr_full(32'h8, 32'h3, 4'hF, 2'b00, "collide_init");
    bus.aw_addr = 32'h8; bus.w_data = 32'h5; bus.w_strb = 4'hF;
    bus.aw_valid = 1; bus.w_valid = 1; bus.b_ready = 1;
    bus.ar_addr = 32'h8; bus.ar_valid = 1; bus.r_ready = 0;
    cyc();
    bus.aw_valid = 0; bus.w_valid = 0; bus.ar_valid = 0;
    checks++; if (bus.r_valid !== 1'b1 || bus.r_data !== 32'h3) begin failures++; $display("FAIL collide_old: got valid=%b data=%h required 1 00000003", bus.r_valid, bus.r_data); end
    checks++; if (word(2) !== 32'h5) begin failures++; $display("FAIL collide_word2: got %h required 5", word(2)); end
    cyc();
    bus.b_ready = 0;
    checks++; if (bus.r_valid !== 1'b1 || bus.r_data !== 32'h3 || bus.r_resp !== 2'b00) begin failures++; $display("FAIL collide_hold: got valid=%b data=%h resp=%b required 1 3 00", bus.r_valid, bus.r_data, bus.r_resp); end
    bus.ar_valid = 1; bus.r_ready = 1;
    cyc();
    bus.ar_valid = 0;
    checks++; if (bus.r_valid !== 1'b1 || bus.r_data !== 32'h5) begin failures++; $display("FAIL collide_new: got valid=%b data=%h required 1 00000005", bus.r_valid, bus.r_data); end
    cyc();
    bus.r_ready = 0;
    checks++; if (bus.r_valid !== 1'b0) begin failures++; $display("FAIL collide_r_drop: got %b required 0", bus.r_valid); end
    $display("txn read collide addr=8");
  endtask

  task automatic test_out_of_range();
    logic [16*32-1:0] snap;
    logic [31:0] data;
    logic [1:0] resp;
    logic got;
    snap = regs;
    wr_full(32'h40, 32'hFFFFFFFF, 4'hF, OOR_RESP, "oor");
    checks++; if (regs !== snap) begin failures++; $display("FAIL oor_regs_changed: got %h required %h", regs, snap); end
    rd(32'h40, data, resp, got);
    checks++; if (!got || data !== 32'h0 || resp !== OOR_RESP) begin failures++; $display("FAIL oor_read: got valid=%b data=%h resp=%b required 1 0 %b", got, data, resp, OOR_RESP); end
    rd(32'h4, data, resp, got);
    checks++; if (!got || data !== 32'hAA22CC44 || resp !== 2'b00) begin failures++; $display("FAIL inrange_read: got valid=%b data=%h resp=%b required 1 aa22cc44 00", got, data, resp); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] data;
    logic [1:0] resp;
    logic got;
    bus.aw_addr = 32'h0; bus.aw_valid = 1;
    cyc();
    bus.aw_valid = 0;
    checks++; if (bus.aw_ready !== 1'b0 || bus.w_ready !== 1'b1) begin failures++; $display("FAIL mid_aw_only: got aw=%b w=%b required 0 1", bus.aw_ready, bus.w_ready); end
    rst = 1;
    #1;
    checks++; if ({bus.aw_ready, bus.w_ready, bus.ar_ready, bus.b_valid, bus.r_valid} !== 5'b0) begin failures++; $display("FAIL mid_rst_outputs: got %b required 00000", {bus.aw_ready, bus.w_ready, bus.ar_ready, bus.b_valid, bus.r_valid}); end
    checks++; if (regs !== '0) begin failures++; $display("FAIL mid_rst_regs: got %h required 0", regs); end
    cyc();
    rst = 0;
    cyc();
    $display("txn reset mid-write");
    wr_full(32'h0, 32'h12345678, 4'hF, 2'b00, "post_mid");
    checks++; if (word(0) !== 32'h12345678) begin failures++; $display("FAIL mid_word0: got %h required 12345678", word(0)); end
    rd(32'h4, data, resp, got);
    checks++; if (!got || data !== 32'h0 || resp !== 2'b00) begin failures++; $display("FAIL mid_read1: got valid=%b data=%h resp=%b required 1 0 00", got, data, resp); end
    rd(32'hC, data, resp, got);
    checks++; if (!got || data !== 32'h0) begin failures++; $display("FAIL mid_read3: got valid=%b data=%h required 1 0", got, data); end
  endtask

  initial begin
    bus.aw_valid = 0; bus.aw_addr = '0; bus.aw_prot = '0;
    bus.w_valid = 0; bus.w_data = '0; bus.w_strb = '0; bus.b_ready = 0;
    bus.ar_valid = 0; bus.ar_addr = '0; bus.ar_prot = '0; bus.r_ready = 0;
    test_reset();
    test_same_cycle();
    test_split();
    test_backpressure();
    test_read_collide();
    test_out_of_range();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end
endmodule
